// File: rtl/demux_pkg.sv
// rtl/demux_pkg.sv - shared constants and helpers for the 1-to-N stream demux
package demux_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_N_CH  = 4;
  localparam int DEF_CNT_W = 8;

  localparam logic [DEF_CNT_W-1:0] DROP_MAX = '1;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// rtl/demux_slot.sv - one-entry output buffer for a single demux channel
module demux_slot #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             out_ready,
  output logic             valid,
  output logic [WIDTH-1:0] data,
  output logic             free
);

  assign free = !valid || out_ready;

  // A load in the same cycle as a drain wins: valid stays high with new data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= load_data;
    end else if (out_ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_stream_1ton.sv
// rtl/demux_stream_1ton.sv - registered 1-to-N stream demux with broadcast and drop counter
module demux_stream_1ton
  import demux_pkg::*;
#(
  parameter  int WIDTH = DEF_WIDTH,
  parameter  int N_CH  = DEF_N_CH,
  parameter  int CNT_W = DEF_CNT_W,
  localparam int SEL_W = clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      in_data,
  input  logic [SEL_W-1:0]      in_sel,
  input  logic                  in_bcast,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [N_CH*WIDTH-1:0] out_data,
  output logic [N_CH-1:0]       out_valid,
  input  logic [N_CH-1:0]       out_ready,
  output logic [CNT_W-1:0]      drop_cnt,
  output logic                  drop_pulse
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [N_CH-1:0] free;
  logic [N_CH-1:0] sel_hot;
  logic [N_CH-1:0] load;
  logic            in_range;
  logic            ready_raw;
  logic            accept;
  logic            drop;

  always_comb begin
    sel_hot = '0;
    for (int k = 0; k < N_CH; k++) begin
      if (in_sel == SEL_W'(k)) sel_hot[k] = 1'b1;
    end
  end

  assign in_range = |sel_hot;

  // Out-of-range selects are always accepted so the producer never stalls on them.
  always_comb begin
    ready_raw = 1'b1;
    if (in_bcast)      ready_raw = &free;
    else if (in_range) ready_raw = |(free & sel_hot);
  end

  assign in_ready = ready_raw && !rst;
  assign accept   = in_valid && in_ready;
  assign drop     = accept && !in_bcast && !in_range;

  always_comb begin
    load = '0;
    if (accept) load = in_bcast ? '1 : sel_hot;
  end

  for (genvar k = 0; k < N_CH; k++) begin : g_slot
    demux_slot #(.WIDTH(WIDTH)) u_slot (
      .clk       (clk),
      .rst       (rst),
      .load      (load[k]),
      .load_data (in_data),
      .out_ready (out_ready[k]),
      .valid     (out_valid[k]),
      .data      (out_data[k*WIDTH +: WIDTH]),
      .free      (free[k])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_cnt   <= '0;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= drop;
      if (drop && drop_cnt != CNT_MAX) drop_cnt <= drop_cnt + 1'b1;
    end
  end

endmodule

// File: doc/demux_stream_1ton.md
Name: demux_stream_1toN

Overview:
- Registered 1-to-N stream demultiplexer with valid/ready handshake. It generalises the 1-to-2 single-bit combinational demux to WIDTH-bit data and N_CH channels.
- Adds a one-entry output buffer per channel, a broadcast mode, and a saturating counter of dropped out-of-range selects.
- Sits between an ALU result/operand bus and multiple consumer units. Each consumer may stall independently.

Parameters:
- WIDTH, 8, data width in bits (>=1)
- N_CH, 4, number of output channels (2..16)
- SEL_W, $clog2(N_CH), select width (derived, not overridable)
- CNT_W, 8, width of drop counter

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous active-high reset
- in_data  input  WIDTH  payload
- in_sel  input  SEL_W  target channel index
- in_bcast  input  1  1 = deliver to all channels, in_sel ignored
- in_valid  input  1  producer has a word
- in_ready  output  1  block accepts word this cycle (combinational)
- out_data  output  N_CH*WIDTH  channel k at bits [k*WIDTH +: WIDTH]
- out_valid  output  N_CH  per-channel valid (registered)
- out_ready  input  N_CH  per-channel consumer ready
- drop_cnt  output  CNT_W  saturating count of dropped words (registered)
- drop_pulse  output  1  registered 1-cycle flag: a drop occurred last cycle

Behaviour:
- Clock and reset: one clock, clk. Reset rst is asynchronous and active-high. While rst=1: out_valid=0, out_data=0, drop_cnt=0, drop_pulse=0, in_ready=0. A reset mid-transfer discards all buffered words, with no partial delivery.
- Slot state: each channel k holds one slot (valid_k, data_k). The slot is free this cycle when !valid_k || out_ready[k].
- Consumer handshake: a consumer transfer happens on out_valid[k] && out_ready[k]. The slot then clears unless refilled in the same cycle.
- Unicast accept: in_bcast=0 and in_sel<N_CH.
  - in_ready = free(in_sel).
  - On in_valid && in_ready, slot in_sel loads in_data and valid_k goes to 1 next edge.
  - Latency: exactly 1 cycle from accept to out_valid.
  - Throughput: full rate, 1 word/cycle, when the consumer holds ready=1. Back-to-back words to the same channel are allowed.
- Broadcast accept: in_bcast=1.
  - in_ready = AND of free(k) over all k.
  - On accept, all N_CH slots load in_data simultaneously. It is never a partial broadcast.
- Out-of-range select: in_bcast=0 and in_sel>=N_CH. This is only possible when N_CH is not a power of 2.
  - in_ready=1 and the word is consumed and discarded.
  - No slot changes.
  - drop_cnt increments and saturates at all-ones; it never wraps.
  - drop_pulse=1 on the following cycle.
- Simultaneous drain and load on the same slot in one edge: the new data wins and valid stays 1.
- Data stability: out_data[k] is stable while out_valid[k]=1 && out_ready[k]=0. No combinational path from in_data to out_data.
- in_ready combinational dependencies: it may depend combinationally on in_sel, in_bcast and out_ready. It must not depend on in_valid.
- Data when invalid: out_data of an invalid slot holds its last value and is not zeroed after reset.
- No internal FSM beyond per-slot valid bits. The drop counter is the only other state.

Decomposition:
- Shared package (demux_pkg):
  - default WIDTH/N_CH constants
  - a clog2 helper function
  - a localparam for the drop-counter max value
- Sub-module demux_slot: one-entry register with load, load_data, out_ready → valid, data, free.
  - Instantiated N_CH times in a generate loop.
- The top level holds the select decode, in_ready logic and drop counter.

Test Plan:
- Reset/idle: assert rst mid-simulation with a slot full (out_valid=4'b0010) → out_valid=0, drop_cnt=0 immediately, without waiting for a clock edge. in_ready=0 during reset.
- Unicast latency: WIDTH=8, N_CH=4, all out_ready=1; send 0xA5 sel=2 → next cycle out_valid=4'b0100, out_data[23:16]=0xA5. The slot clears the cycle after.
- Backpressure:
  - out_ready[1]=0; send 0x11 sel=1, then 0x22 sel=1 → in_ready=0 on the second word; out_data[15:8] stays 0x11.
  - Raise out_ready[1] → 0x22 is accepted in that same cycle and appears next cycle.
- Broadcast gating:
  - out_ready=4'b1110 with slot 0 full; send 0x3C bcast=1 → in_ready=0, no slot changes.
  - Release out_ready[0] → all four channels show 0x3C next cycle.
- Drop/saturate: N_CH=3, CNT_W=2; send 5 words with sel=3 → drop_pulse high each following cycle; drop_cnt 1,2,3,3,3; out_valid stays 0.
- Random stress: random sel/bcast/valid/out_ready for 10k cycles → scoreboard shows per-channel in-order delivery, with no loss or duplication except counted drops.
